// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode and select encodings for the multicycle controller
package mips_ctrl_pkg;

   // Controller states; three 4-bit encodings are unused and recover to FETCH
   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADR   = 4'd2,
      ST_MEMRD    = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWR    = 4'd5,
      ST_RTEX     = 4'd6,
      ST_RTWB     = 4'd7,
      ST_IMMEX    = 4'd8,
      ST_IMMWB    = 4'd9,
      ST_BRANCH   = 4'd10,
      ST_JUMP     = 4'd11,
      ST_BRANCHNE = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_DADDI = 6'b011000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_AND   = 3'b001;
   localparam logic [2:0] ALUOP_OR    = 3'b010;
   localparam logic [2:0] ALUOP_SLT   = 3'b011;
   localparam logic [2:0] ALUOP_DADD  = 3'b100;
   localparam logic [2:0] ALUOP_SUB   = 3'b101;
   localparam logic [2:0] ALUOP_RTYPE = 3'b111;

   localparam logic [1:0] ALUSRCB_RT    = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
   localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_imm_aluop.sv
// rtl/mc_imm_aluop.sv - opcode to ALU operation class map for immediate instructions
module mc_imm_aluop
   import mips_ctrl_pkg::*;
#(
   parameter int OPW  = 6,
   parameter int AOPW = 3
) (
   input  logic [OPW-1:0]  op,
   output logic [AOPW-1:0] aluop
);

   // Select the ALU class for an immediate opcode; non-immediate opcodes fall back to ADD
   always_comb begin
      aluop = AOPW'(ALUOP_ADD);
      if      (op == OPW'(OP_ANDI))  aluop = AOPW'(ALUOP_AND);
      else if (op == OPW'(OP_ORI))   aluop = AOPW'(ALUOP_OR);
      else if (op == OPW'(OP_SLTI))  aluop = AOPW'(ALUOP_SLT);
      else if (op == OPW'(OP_DADDI)) aluop = AOPW'(ALUOP_DADD);
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS main controller; MC_CTRL_BNE_EN adds BNE and the branch_ne output
module mc_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int OPW  = 6,
   parameter int AOPW = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OPW-1:0]  op,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            pcwrite,
   output logic            pcwritecond,
   output logic            iord,
   output logic            memread,
   output logic            memwrite,
   output logic            irwrite,
   output logic            regdst,
   output logic            memtoreg,
   output logic            regwrite,
   output logic            alusrca,
   output logic [1:0]      alusrcb,
   output logic [1:0]      pcsrc,
   output logic [AOPW-1:0] aluop,
`ifdef MC_CTRL_BNE_EN
   output logic            branch_ne,
`endif
   output logic            illegal
);

   state_e          state_q;
   state_e          state_d;
   logic [AOPW-1:0] imm_aluop;
   logic            unused_zero;

   // zero is consumed by the datapath branch qualifier, never by the state sequence
   assign unused_zero = zero;

   mc_imm_aluop #(.OPW(OPW), .AOPW(AOPW)) u_imm_aluop (
      .op    (op),
      .aluop (imm_aluop)
   );

   // State register; reset aborts any access in flight and restarts at FETCH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_FETCH;
      else       state_q <= state_d;
   end

   // Next-state and per-state datapath controls
   always_comb begin
      state_d     = state_q;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      regdst      = 1'b0;
      memtoreg    = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = ALUSRCB_RT;
      pcsrc       = PCSRC_ALU;
      aluop       = AOPW'(ALUOP_ADD);
      illegal     = 1'b0;
`ifdef MC_CTRL_BNE_EN
      branch_ne   = 1'b0;
`endif
      case (state_q)
         ST_FETCH: begin
            memread = 1'b1;
            alusrcb = ALUSRCB_FOUR;
            // IR and PC+4 are committed only when the instruction word arrives
            if (mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alusrcb = ALUSRCB_IMMSH;
            if (op == OPW'(OP_LW) || op == OPW'(OP_SW)) state_d = ST_MEMADR;
            else if (op == OPW'(OP_RTYPE))                state_d = ST_RTEX;
            else if (op == OPW'(OP_BEQ))                  state_d = ST_BRANCH;
            else if (op == OPW'(OP_ADDI) || op == OPW'(OP_ANDI) || op == OPW'(OP_ORI) ||
                     op == OPW'(OP_SLTI) || op == OPW'(OP_DADDI))
               state_d = ST_IMMEX;
            else if (op == OPW'(OP_J))                    state_d = ST_JUMP;
`ifdef MC_CTRL_BNE_EN
            else if (op == OPW'(OP_BNE))                  state_d = ST_BRANCHNE;
`endif
            else begin
               illegal = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = ALUSRCB_IMM;
            state_d = (op == OPW'(OP_SW)) ? ST_MEMWR : ST_MEMRD;
         end
         ST_MEMRD: begin
            iord    = 1'b1;
            memread = 1'b1;
            if (mem_ready) state_d = ST_MEMWB;
         end
         ST_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_MEMWR: begin
            iord     = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) state_d = ST_FETCH;
         end
         ST_RTEX: begin
            alusrca = 1'b1;
            aluop   = AOPW'(ALUOP_RTYPE);
            state_d = ST_RTWB;
         end
         ST_RTWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = ALUSRCB_IMM;
            aluop   = imm_aluop;
            state_d = ST_IMMWB;
         end
         ST_IMMWB: begin
            regwrite = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_BRANCH: begin
            alusrca     = 1'b1;
            aluop       = AOPW'(ALUOP_SUB);
            pcwritecond = 1'b1;
            pcsrc       = PCSRC_ALUOUT;
            state_d     = ST_FETCH;
         end
         ST_JUMP: begin
            pcwrite = 1'b1;
            pcsrc   = PCSRC_JUMP;
            state_d = ST_FETCH;
         end
`ifdef MC_CTRL_BNE_EN
         ST_BRANCHNE: begin
            alusrca     = 1'b1;
            aluop       = AOPW'(ALUOP_SUB);
            pcwritecond = 1'b1;
            pcsrc       = PCSRC_ALUOUT;
            branch_ne   = 1'b1;
            state_d     = ST_FETCH;
         end
`endif
         default: state_d = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] op = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic       regdst, memtoreg, regwrite, alusrca, illegal;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluop;
   logic [17:0] outs;
   int         checks = 0;
   int         errors = 0;

   // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,aluop,illegal}
   localparam logic [17:0] E_FW    = 18'b0_0_0_1_0_0_0_0_0_0_01_00_000_0;
   localparam logic [17:0] E_FD    = 18'b1_0_0_1_0_1_0_0_0_0_01_00_000_0;
   localparam logic [17:0] E_DEC   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_000_0;
   localparam logic [17:0] E_ILL   = 18'b0_0_0_0_0_0_0_0_0_0_11_00_000_1;
   localparam logic [17:0] E_MADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_000_0;
   localparam logic [17:0] E_MRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_000_0;
   localparam logic [17:0] E_MWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_000_0;
   localparam logic [17:0] E_MWR   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_000_0;
   localparam logic [17:0] E_RTEX  = 18'b0_0_0_0_0_0_0_0_0_1_00_00_111_0;
   localparam logic [17:0] E_RTWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_000_0;
   localparam logic [17:0] E_IMADD = 18'b0_0_0_0_0_0_0_0_0_1_10_00_000_0;
   localparam logic [17:0] E_IMWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_000_0;
   localparam logic [17:0] E_BR    = 18'b0_1_0_0_0_0_0_0_0_1_00_01_101_0;
   localparam logic [17:0] E_JMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_10_000_0;

   assign outs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regdst,
                  memtoreg, regwrite, alusrca, alusrcb, pcsrc, aluop, illegal};

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.OPW(6), .AOPW(3)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
      .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .aluop(aluop), .illegal(illegal)
   );

   // Apply inputs just after a falling edge and let combinational outputs settle
   task automatic drive(input logic [5:0] o, input logic m, input logic z);
      op = o; mem_ready = m; zero = z;
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (outs !== E_FW) begin
         errors++; $display("FAIL reset_state: got %b expected %b", outs, E_FW);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      logic [17:0] ex [4] = '{E_FD, E_DEC, E_MADR, E_MWR};
      logic        mr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [17:0] ex2 [5] = '{E_FD, E_DEC, E_MADR, E_MWR, E_FW};
      logic        mr2 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive(6'b101011, mr[i], 1'b0);
         checks++;
         if (outs !== ex[i]) begin
            errors++; $display("FAIL sw_pre_reset cycle %0d: got %b expected %b", i, outs, ex[i]);
         end
         if (i < 3) @(negedge clk);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (outs !== E_FW) begin
         errors++; $display("FAIL reset_mid_memwr: got %b expected %b", outs, E_FW);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(6'b101011, mr2[i], 1'b0);
         checks++;
         if (outs !== ex2[i]) begin
            errors++; $display("FAIL sw_after_reset cycle %0d: got %b expected %b", i, outs, ex2[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_addi();
      logic [17:0] ex [5] = '{E_FD, E_DEC, E_IMADD, E_IMWB, E_FW};
      logic        mr [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(6'b001000, mr[i], 1'b0);
         checks++;
         if (outs !== ex[i]) begin
            errors++; $display("FAIL addi cycle %0d: got %b expected %b", i, outs, ex[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_imm_ops();
      logic [5:0] ops [4] = '{6'b001100, 6'b001101, 6'b001010, 6'b011000};
      logic [2:0] aop [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
      logic [17:0] ex [5];
      for (int k = 0; k < 4; k++) begin
         ex = '{E_FD, E_DEC, {14'b00000000011000, aop[k], 1'b0}, E_IMWB, E_FW};
         for (int i = 0; i < 5; i++) begin
            drive(ops[k], (i < 4), 1'b0);
            checks++;
            if (outs !== ex[i]) begin
               errors++; $display("FAIL imm_op %b cycle %0d: got %b expected %b", ops[k], i, outs, ex[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_lw_wait();
      logic [17:0] ex [9] = '{E_FW, E_FD, E_DEC, E_MADR, E_MRD, E_MRD, E_MRD, E_MWB, E_FW};
      logic        mr [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 9; i++) begin
         drive(6'b100011, mr[i], 1'b0);
         checks++;
         if (outs !== ex[i]) begin
            errors++; $display("FAIL lw_wait cycle %0d: got %b expected %b", i, outs, ex[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [17:0] ex [4] = '{E_FD, E_DEC, E_BR, E_FW};
      for (int z = 0; z < 2; z++) begin
         for (int i = 0; i < 4; i++) begin
            drive(6'b000100, (i < 3), z[0]);
            checks++;
            if (outs !== ex[i]) begin
               errors++; $display("FAIL beq zero=%0d cycle %0d: got %b expected %b", z, i, outs, ex[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_jump();
      logic [17:0] ex [4] = '{E_FD, E_DEC, E_JMP, E_FW};
      for (int i = 0; i < 4; i++) begin
         drive(6'b000010, (i < 3), 1'b0);
         checks++;
         if (outs !== ex[i]) begin
            errors++; $display("FAIL jump cycle %0d: got %b expected %b", i, outs, ex[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal();
      logic [5:0]  ops [2] = '{6'b111111, 6'b000101};
      logic [17:0] ex [3] = '{E_FD, E_ILL, E_FW};
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 3; i++) begin
            drive(ops[k], (i < 2), 1'b0);
            checks++;
            if (outs !== ex[i]) begin
               errors++; $display("FAIL illegal op %b cycle %0d: got %b expected %b", ops[k], i, outs, ex[i]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_rtype();
      logic [17:0] ex [5] = '{E_FD, E_DEC, E_RTEX, E_RTWB, E_FW};
      for (int i = 0; i < 5; i++) begin
         drive(6'b000000, (i == 0), 1'b0);
         checks++;
         if (outs !== ex[i]) begin
            errors++; $display("FAIL rtype cycle %0d: got %b expected %b", i, outs, ex[i]);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_imm_ops();
      test_lw_wait();
      test_branch();
      test_jump();
      test_illegal();
      test_rtype();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
